// File: rtl/ibex_scramble_key_mgr_pkg.sv
// Shared types and constants for the multi-channel scramble key manager.
package ibex_scramble_key_mgr_pkg;

  localparam int unsigned SCR_MGR_MAX_CHANNELS = 8;
  localparam int unsigned SCRAMBLE_KEY_W       = 128;
  localparam int unsigned SCRAMBLE_NONCE_W     = 64;

  localparam logic [SCRAMBLE_KEY_W-1:0] RndCnstIbexKeyDefault =
    128'h14e8cecae3040d5e12286bb3cc113298;
  localparam logic [SCRAMBLE_NONCE_W-1:0] RndCnstIbexNonceDefault =
    64'hf79780bc735f3843;

  typedef enum logic [1:0] {
    SCR_MGR_IDLE    = 2'd0,
    SCR_MGR_REQ     = 2'd1,
    SCR_MGR_BACKOFF = 2'd2
  } scr_mgr_state_e;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int unsigned scr_mgr_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ibex_scramble_rr_arb.sv
// Combinational round-robin pick: first requester at or after the pointer.
module ibex_scramble_rr_arb import ibex_scramble_key_mgr_pkg::*; #(
  parameter int unsigned NumChannels = 2,
  localparam int unsigned IdxW = scr_mgr_idx_w(NumChannels)
) (
  input  logic [NumChannels-1:0] req_i,
  input  logic [IdxW-1:0]        ptr_i,
  output logic [IdxW-1:0]        grant_o,
  output logic                   valid_o
);

  int unsigned     idx;
  logic [IdxW-1:0] sel;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant_o = '0;
    valid_o = |req_i;
    idx     = 0;
    sel     = '0;
    for (int i = int'(NumChannels) - 1; i >= 0; i--) begin
      idx = 32'(ptr_i) + 32'(i);
      if (idx >= NumChannels) begin
        idx = idx - NumChannels;
      end
      sel = IdxW'(idx);
      if (req_i[sel]) begin
        grant_o = sel;
      end
    end
  end

endmodule

// File: rtl/ibex_scramble_key_mgr.sv
// Multi-channel scramble key manager sharing one OTP key port.
module ibex_scramble_key_mgr import ibex_scramble_key_mgr_pkg::*; #(
  parameter int unsigned          NumChannels   = 2,
  parameter int unsigned          KeyW          = SCRAMBLE_KEY_W,
  parameter int unsigned          NonceW        = SCRAMBLE_NONCE_W,
  parameter logic [KeyW-1:0]      RndCnstKey    = RndCnstIbexKeyDefault,
  parameter logic [NonceW-1:0]    RndCnstNonce  = RndCnstIbexNonceDefault,
  parameter int unsigned          TimeoutCycles = 1024,
  localparam int unsigned         IdxW          = scr_mgr_idx_w(NumChannels)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumChannels-1:0]             chan_req_i,
  output logic [NumChannels-1:0][KeyW-1:0]   chan_key_o,
  output logic [NumChannels-1:0][NonceW-1:0] chan_nonce_o,
  output logic [NumChannels-1:0]             chan_key_valid_o,
  output logic                               otp_req_o,
  output logic [IdxW-1:0]                    otp_chan_o,
  input  logic                               otp_ack_i,
  input  logic [KeyW-1:0]                    otp_key_i,
  input  logic [NonceW-1:0]                  otp_nonce_i,
  output logic                               busy_o,
  output logic                               err_timeout_o
);

  localparam int unsigned CntW        = 16;
  localparam bit          TimeoutEn   = (TimeoutCycles != 0);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);

  scr_mgr_state_e         state_q;
  logic [NumChannels-1:0] pending_q;
  logic [IdxW-1:0]        grant_q;
  logic [IdxW-1:0]        rr_ptr_q;
  logic [CntW-1:0]        cnt_q;

  logic [IdxW-1:0]        arb_grant;
  logic                   arb_valid;
  logic                   ack_accept;
  logic                   timeout_hit;
  logic [IdxW-1:0]        next_ptr;
  logic [NumChannels-1:0] ack_clr;

  ibex_scramble_rr_arb #(
    .NumChannels(NumChannels)
  ) u_arb (
    .req_i  (pending_q),
    .ptr_i  (rr_ptr_q),
    .grant_o(arb_grant),
    .valid_o(arb_valid)
  );

  assign ack_accept  = (state_q == SCR_MGR_REQ) && otp_ack_i;
  assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);
  assign next_ptr    = (grant_q == IdxW'(NumChannels - 1)) ? '0 : grant_q + IdxW'(1);
  assign otp_chan_o  = grant_q;
  assign busy_o      = (|pending_q) || (state_q != SCR_MGR_IDLE);

  // One-hot of the slot being written by an accepted ack.
  always_comb begin
    ack_clr = '0;
    if (ack_accept) begin
      ack_clr[grant_q] = 1'b1;
    end
  end

  // Refresh sequencer: grant, request, await ack or time out and back off.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= SCR_MGR_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      otp_req_o     <= 1'b0;
      err_timeout_o <= 1'b0;
    end else begin
      err_timeout_o <= 1'b0;
      case (state_q)
        SCR_MGR_IDLE: begin
          if (arb_valid) begin
            grant_q   <= arb_grant;
            cnt_q     <= '0;
            otp_req_o <= 1'b1;
            state_q   <= SCR_MGR_REQ;
          end
        end
        SCR_MGR_REQ: begin
          if (otp_ack_i) begin
            rr_ptr_q  <= next_ptr;
            cnt_q     <= '0;
            otp_req_o <= 1'b0;
            state_q   <= SCR_MGR_IDLE;
          end else if (timeout_hit) begin
            rr_ptr_q      <= next_ptr;
            cnt_q         <= '0;
            otp_req_o     <= 1'b0;
            err_timeout_o <= 1'b1;
            state_q       <= SCR_MGR_BACKOFF;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        SCR_MGR_BACKOFF: begin
          state_q <= SCR_MGR_IDLE;
        end
        default: begin
          otp_req_o <= 1'b0;
          state_q   <= SCR_MGR_IDLE;
        end
      endcase
    end
  end

  // Per-channel pending/valid flags and key/nonce slots; a fresh request beats a same-cycle ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q        <= '0;
      chan_key_valid_o <= '1;
      chan_key_o       <= {NumChannels{RndCnstKey}};
      chan_nonce_o     <= {NumChannels{RndCnstNonce}};
    end else begin
      pending_q        <= (pending_q & ~ack_clr) | chan_req_i;
      chan_key_valid_o <= (chan_key_valid_o | ack_clr) & ~chan_req_i;
      if (ack_accept) begin
        chan_key_o[grant_q]   <= otp_key_i;
        chan_nonce_o[grant_q] <= otp_nonce_i;
      end
    end
  end

endmodule

// File: tb/tb_ibex_scramble_key_mgr.sv
// Scoreboard bench for ibex_scramble_key_mgr with two channels and a short timeout.
module tb_ibex_scramble_key_mgr;
  import ibex_scramble_key_mgr_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned TO = 4;
  localparam logic [127:0] KDEF = 128'h3c1e9a5f0b7d42e681c4f0a25d39e7b8;
  localparam logic [63:0]  NDEF = 64'h9e3779b97f4a7c15;

  typedef struct {
    int           chan;
    logic [127:0] key;
    logic [63:0]  nonce;
    logic         valid;
  } sb_t;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic [N-1:0]           chan_req_i;
  logic [N-1:0][127:0]    chan_key_o;
  logic [N-1:0][63:0]     chan_nonce_o;
  logic [N-1:0]           chan_key_valid_o;
  logic                   otp_req_o;
  logic [0:0]             otp_chan_o;
  logic                   otp_ack_i;
  logic [127:0]           otp_key_i;
  logic [63:0]            otp_nonce_i;
  logic                   busy_o;
  logic                   err_timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] exp_key[N];
  logic [63:0]  exp_nonce[N];
  logic         exp_valid[N];
  int           chan_q[$];
  sb_t          key_sb[$];

  always #5 clk = ~clk;

  ibex_scramble_key_mgr #(
    .NumChannels  (N),
    .KeyW         (128),
    .NonceW       (64),
    .RndCnstKey   (KDEF),
    .RndCnstNonce (NDEF),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .chan_req_i      (chan_req_i),
    .chan_key_o      (chan_key_o),
    .chan_nonce_o    (chan_nonce_o),
    .chan_key_valid_o(chan_key_valid_o),
    .otp_req_o       (otp_req_o),
    .otp_chan_o      (otp_chan_o),
    .otp_ack_i       (otp_ack_i),
    .otp_key_i       (otp_key_i),
    .otp_nonce_i     (otp_nonce_i),
    .busy_o          (busy_o),
    .err_timeout_o   (err_timeout_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_slots(input string tag);
    for (int c = 0; c < int'(N); c++) begin
      check($sformatf("%s_key%0d", tag, c), chan_key_o[c], exp_key[c]);
      check($sformatf("%s_nonce%0d", tag, c), 128'(chan_nonce_o[c]), 128'(exp_nonce[c]));
      check($sformatf("%s_valid%0d", tag, c), 128'(chan_key_valid_o[c]), 128'(exp_valid[c]));
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < int'(N); c++) begin
      exp_key[c]   = KDEF;
      exp_nonce[c] = NDEF;
      exp_valid[c] = 1'b1;
    end
    chan_q.delete();
    key_sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    model_reset();
  endtask

  // Pulse a request vector for one cycle; the model drops valid for each requester.
  task automatic pulse_req(input logic [N-1:0] v);
    @(negedge clk);
    chan_req_i = v;
    @(negedge clk);
    chan_req_i = '0;
    for (int c = 0; c < int'(N); c++) begin
      if (v[c]) exp_valid[c] = 1'b0;
    end
  endtask

  // Bounded wait for otp_req_o, then check the served channel against the expected order.
  task automatic wait_req(output bit ok, output int chan);
    int cyc = 0;
    while (otp_req_o !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    ok = (otp_req_o === 1'b1);
    check("req_seen", 128'(ok), 128'(1));
    chan = (chan_q.size() > 0) ? chan_q.pop_front() : -1;
    if (ok) check("otp_chan", 128'(otp_chan_o), 128'(chan));
  endtask

  // Ack in the hold-th REQ cycle; optionally re-request the same channel in the ack cycle.
  task automatic serve(input int hold, input logic [127:0] k, input logic [63:0] n, input bit rereq);
    bit  ok;
    int  c;
    sb_t e;
    wait_req(ok, c);
    if (ok && c >= 0) begin
      repeat (hold - 1) @(negedge clk);
      check("req_held", 128'(otp_req_o), 128'(1));
      otp_ack_i   = 1'b1;
      otp_key_i   = k;
      otp_nonce_i = n;
      if (rereq) begin
        chan_req_i[c] = 1'b1;
        chan_q.push_back(c);
      end
      key_sb.push_back('{c, k, n, !rereq});
      @(negedge clk);
      otp_ack_i   = 1'b0;
      chan_req_i  = '0;
      otp_key_i   = {4{$urandom}};
      otp_nonce_i = {2{$urandom}};
      e = key_sb.pop_front();
      exp_key[e.chan]   = e.key;
      exp_nonce[e.chan] = e.nonce;
      exp_valid[e.chan] = e.valid;
      check("ack_req_drop", 128'(otp_req_o), 128'(0));
      check_slots("ack");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c, hi, lo, errs;
    rst_i       = 1'b1;
    chan_req_i  = '0;
    otp_ack_i   = 1'b0;
    otp_key_i   = '0;
    otp_nonce_i = '0;
    do_reset();

    // Reset state
    check("rst_req", 128'(otp_req_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_err", 128'(err_timeout_o), 128'(0));
    check("rst_chan", 128'(otp_chan_o), 128'(0));
    check_slots("rst");

    // Single request on ch0, ack in third REQ cycle
    chan_q.push_back(0);
    pulse_req(2'b01);
    check("t1_busy", 128'(busy_o), 128'(1));
    check("t1_req", 128'(otp_req_o), 128'(0));
    check_slots("t1");
    @(negedge clk);
    check("t2_req", 128'(otp_req_o), 128'(1));
    serve(3, {16{8'hA5}}, {8{8'h5A}}, 1'b0);

    // Simultaneous requests, twice, from a reset pointer: order 0,1 both times
    do_reset();
    for (int it = 0; it < 2; it++) begin
      chan_q.push_back(0);
      chan_q.push_back(1);
      pulse_req(2'b11);
      serve(3, {4{32'h1000_0000 + 32'(it)}}, {2{32'h2000_0000 + 32'(it)}}, 1'b0);
      serve(3, {4{32'h3000_0000 + 32'(it)}}, {2{32'h4000_0000 + 32'(it)}}, 1'b0);
    end
    check("rr_idle_busy", 128'(busy_o), 128'(0));

    // Timeout: REQ high TO cycles, one error pulse, two low cycles with ignored acks, retry
    chan_q.push_back(0);
    pulse_req(2'b01);
    wait_req(ok, c);
    hi = 0;
    errs = 0;
    while (otp_req_o === 1'b1 && hi < 20) begin
      errs += int'(err_timeout_o);
      hi++;
      @(negedge clk);
    end
    check("to_high", 128'(hi), 128'(TO));
    check("to_err_now", 128'(err_timeout_o), 128'(1));
    lo = 0;
    while (otp_req_o !== 1'b1 && lo < 20) begin
      errs += int'(err_timeout_o);
      otp_ack_i = 1'b1;
      otp_key_i = {4{32'hDEAD_BEEF}};
      lo++;
      @(negedge clk);
    end
    otp_ack_i = 1'b0;
    check("to_low", 128'(lo), 128'(2));
    check("to_errs", 128'(errs), 128'(1));
    check_slots("to_ign");
    chan_q.push_back(0);
    serve(1, {4{32'hC0DE_0001}}, {2{32'hC0DE_0002}}, 1'b0);

    // Re-request in the ack cycle: key stored, valid stays 0, second REQ for ch0
    chan_q.push_back(0);
    pulse_req(2'b01);
    serve(3, {4{32'hBBBB_0001}}, {2{32'hBBBB_0002}}, 1'b1);
    check("rereq_busy", 128'(busy_o), 128'(1));
    serve(2, {4{32'hCCCC_0001}}, {2{32'hCCCC_0002}}, 1'b0);

    // Reset mid-REQ with an ack landing on the reset edge
    chan_q.push_back(1);
    pulse_req(2'b10);
    wait_req(ok, c);
    rst_i       = 1'b1;
    otp_ack_i   = 1'b1;
    otp_key_i   = {4{32'hFFFF_0000}};
    otp_nonce_i = {2{32'hFFFF_1111}};
    @(negedge clk);
    model_reset();
    check("rstmid_req", 128'(otp_req_o), 128'(0));
    check("rstmid_busy", 128'(busy_o), 128'(0));
    check_slots("rstmid");
    @(negedge clk);
    rst_i     = 1'b0;
    otp_ack_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_req", 128'(otp_req_o), 128'(0));
    end
    check_slots("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
